// File: rtl/seq_det_1011_pkg.sv
// Shared definitions for the 1011 serial pattern detector.
//   state_t    : 3-bit FSM encoding, S_IDLE=0 .. S_1011=4
//   PATTERN    : the detected bit pattern, oldest bit in the MSB
//   next_state : transition function for one sampled bit
package seq_det_1011_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_101  = 3'd3,
    S_1011 = 3'd4
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

  // overlap only matters on the way out of S_1011: with overlap the
  // trailing "1" of a match is reused as the first bit of the next one.
  function automatic state_t next_state(input state_t s, input logic d,
                                        input logic overlap);
    state_t n;
    n = S_IDLE;
    unique case (s)
      S_IDLE: n = d ? S_1    : S_IDLE;
      S_1:    n = d ? S_1    : S_10;
      S_10:   n = d ? S_101  : S_IDLE;
      S_101:  n = d ? S_1011 : S_10;
      S_1011: n = d ? S_1    : (overlap ? S_10 : S_IDLE);
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_det_1011_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset, count -> 0
//   clr     : synchronous clear, wins over inc
//   inc     : add one unless already all-ones
//   count   : current value, never wraps
module seq_det_1011_sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_1011.sv
// Serial 1011 detector (Moore FSM) with match pulse, saturating match
// count and a shift register of the most recent input bits.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   en      : sample enable, all state holds when low
//   d       : serial data bit
//   overlap : 1 = overlapping matches, 0 = restart after each match
//   clr     : synchronous clear of the match count only
//   match   : registered one-cycle detection pulse
//   count   : saturating number of detections
//   hist    : last HIST_W sampled bits, LSB newest
//
// state  | meaning
// S_IDLE | no useful prefix seen
// S_1    | prefix "1"
// S_10   | prefix "10"
// S_101  | prefix "101"
// S_1011 | full pattern just received
module seq_det_1011
  import seq_det_1011_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int HIST_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              d,
  input  logic              overlap,
  input  logic              clr,
  output logic              match,
  output logic [CNT_W-1:0]  count,
  output logic [HIST_W-1:0] hist
);

  state_t state;
  state_t state_nxt;
  logic   match_nxt;

  always_comb begin
    state_nxt = next_state(state, d, overlap);
    match_nxt = en && (state_nxt == S_1011);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      match <= 1'b0;
      hist  <= '0;
    end else begin
      // match is a pulse: it drops whenever en is low, even while the
      // FSM is parked in S_1011.
      match <= match_nxt;
      if (en) begin
        state <= state_nxt;
        hist  <= {hist[HIST_W-2:0], d};
      end
    end
  end

  seq_det_1011_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (match_nxt),
    .count   (count)
  );

endmodule

// File: tb/tb_seq_det_1011.sv
module tb_seq_det_1011;

  localparam int CNT_W  = 2;
  localparam int HIST_W = 8;

  logic              clk;
  logic              reset_n;
  logic              en;
  logic              d;
  logic              overlap;
  logic              clr;
  logic              match;
  logic [CNT_W-1:0]  count;
  logic [HIST_W-1:0] hist;

  seq_det_1011 #(.CNT_W(CNT_W), .HIST_W(HIST_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .d       (d),
    .overlap (overlap),
    .clr     (clr),
    .match   (match),
    .count   (count),
    .hist    (hist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              m;
    logic [CNT_W-1:0]  c;
    logic [HIST_W-1:0] h;
    int                id;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  logic [HIST_W-1:0] exp_hist;
  int                n_checks;
  int                n_errors;
  int                step_id;

  // Drive one sample on the falling edge and queue the response expected
  // after the next rising edge. Match and count are hand-computed at the
  // call site; hist follows the simple shift definition.
  task automatic step(input logic rn, input logic en_i, input logic d_i,
                      input logic ov, input logic cl,
                      input logic em, input int ec);
    exp_t e;
    @(negedge clk);
    reset_n = rn;
    en      = en_i;
    d       = d_i;
    overlap = ov;
    clr     = cl;
    if (!rn)       exp_hist = '0;
    else if (en_i) exp_hist = {exp_hist[HIST_W-2:0], d_i};
    e.m  = em;
    e.c  = CNT_W'(ec);
    e.h  = exp_hist;
    e.id = step_id;
    exp_q.push_back(e);
    step_id++;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks += 3;
      if (match !== mon_e.m) begin
        n_errors++;
        $display("FAIL match step=%0d got=%b want=%b", mon_e.id, match, mon_e.m);
      end
      if (count !== mon_e.c) begin
        n_errors++;
        $display("FAIL count step=%0d got=%0d want=%0d", mon_e.id, count, mon_e.c);
      end
      if (hist !== mon_e.h) begin
        n_errors++;
        $display("FAIL hist step=%0d got=%b want=%b", mon_e.id, hist, mon_e.h);
      end
    end
  end

  initial begin
    int budget;
    n_checks = 0;
    n_errors = 0;
    step_id  = 0;
    exp_hist = '0;
    reset_n  = 1'b0;
    en       = 1'b1;
    d        = 1'b1;
    overlap  = 1'b1;
    clr      = 1'b0;

    // reset held 2 edges with d=1, en=1
    step(0,1,1,1,0, 0,0);
    step(0,1,1,1,0, 0,0);

    // overlap on: 1,0,1,1,0,1,1 -> matches after bits 4 and 7
    step(1,1,1,1,0, 0,0);
    step(1,1,0,1,0, 0,0);
    step(1,1,1,1,0, 0,0);
    step(1,1,1,1,0, 1,1);
    step(1,1,0,1,0, 0,1);
    step(1,1,1,1,0, 0,1);
    step(1,1,1,1,0, 1,2);   // hist = 8'b01011011

    // overlap off: same stream -> only the first match
    step(0,1,0,0,0, 0,0);
    step(1,1,1,0,0, 0,0);
    step(1,1,0,0,0, 0,0);
    step(1,1,1,0,0, 0,0);
    step(1,1,1,0,0, 1,1);
    step(1,1,0,0,0, 0,1);
    step(1,1,1,0,0, 0,1);
    step(1,1,1,0,0, 0,1);

    // enable gating: 1,0,1 then en=0 x3 with d toggling, then 1
    step(0,1,0,1,0, 0,0);
    step(1,1,1,1,0, 0,0);
    step(1,1,0,1,0, 0,0);
    step(1,1,1,1,0, 0,0);
    step(1,0,1,1,0, 0,0);
    step(1,0,0,1,0, 0,0);
    step(1,0,1,1,0, 0,0);
    step(1,1,1,1,0, 1,1);
    // parked in S_1011 with en=0: no pulse, state kept, so 0,1,1
    // (overlap) completes another match
    step(1,0,0,1,0, 0,1);
    step(1,1,0,1,0, 0,1);
    step(1,1,1,1,0, 0,1);
    step(1,1,1,1,0, 1,2);

    // saturation: 1011 x5 with overlap off, count 1,2,3,3,3
    step(0,1,0,0,0, 0,0);
    for (int r = 1; r <= 5; r++) begin
      step(1,1,1,0,0, 0, r-1 > 3 ? 3 : r-1);
      step(1,1,0,0,0, 0, r-1 > 3 ? 3 : r-1);
      step(1,1,1,0,0, 0, r-1 > 3 ? 3 : r-1);
      step(1,1,1,0,0, 1, r   > 3 ? 3 : r);
    end
    // 6th match with clr on the same edge: count cleared, match still pulses
    step(1,1,1,0,0, 0,3);
    step(1,1,0,0,0, 0,3);
    step(1,1,1,0,0, 0,3);
    step(1,1,1,0,1, 1,0);
    step(1,1,0,0,0, 0,0);

    // reset mid-pattern: 1,0,1, reset, 1,1 -> no match, then 0,1,1 matches
    step(1,1,1,1,0, 0,0);
    step(1,1,0,1,0, 0,0);
    step(1,1,1,1,0, 0,0);
    step(0,1,0,1,0, 0,0);
    step(1,1,1,1,0, 0,0);
    step(1,1,1,1,0, 0,0);   // hist low bits = 2'b11
    step(1,1,0,1,0, 0,0);
    step(1,1,1,1,0, 0,0);
    step(1,1,1,1,0, 1,1);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
